sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder.sv | 154 +++++++++++++++
 tb/tb_sample_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sample_feeder.sv
// Sample memory plus streaming FSM: presents stored (x1, x2, t) samples to a consumer
// one at a time over a request/ready handshake, wrapping and counting epochs.
module sample_feeder #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       nSamples,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic signed [6:0] wrX1,
    input  logic signed [6:0] wrX2,
    input  logic signed [1:0] wrT,
    input  logic              requestFlag,
    input  logic              done,
    output logic signed [6:0] x1Out,
    output logic signed [6:0] x2Out,
    output logic signed [1:0] tOut,
    output logic              dataReady,
    output logic              busy,
    output logic [15:0]       epoch,
    output logic              err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_REQ = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    logic [15:0] mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [15:0]       epoch_q, epoch_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              dr_q, dr_d;
    logic [6:0]        x1_q, x1_d;
    logic [6:0]        x2_q, x2_d;
    logic [1:0]        t_q, t_d;

    logic        mem_we;
    logic [15:0] rd_data;
    logic        n_valid;

    // Memory is not reset so loaded samples survive a reset.
    assign mem_we = wrEn && !rst && (state_q == IDLE) && (32'(wrAddr) < DEPTH);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wrAddr] <= {wrX1, wrX2, wrT};
        end
    end

    assign rd_data = mem_q[idx_q];
    assign n_valid = (nSamples != 32'd0) && (nSamples <= DEPTH);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        epoch_d = epoch_q;
        busy_d  = busy_q;
        err_d   = err_q;
        dr_d    = dr_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_valid) begin
                        last_d  = ADDR_W'(nSamples - 32'd1);
                        idx_d   = '0;
                        epoch_d = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = WAIT_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_REQ: begin
                if (done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (requestFlag) begin
                    x1_d    = rd_data[15:9];
                    x2_d    = rd_data[8:2];
                    t_d     = rd_data[1:0];
                    dr_d    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (done) begin
                    dr_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!requestFlag) begin
                    dr_d    = 1'b0;
                    state_d = WAIT_REQ;
                    if (idx_q == last_q) begin
                        idx_d = '0;
                        if (epoch_q != 16'hFFFF) begin
                            epoch_d = epoch_q + 16'd1;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            epoch_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dr_q    <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            epoch_q <= epoch_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            dr_q    <= dr_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            t_q     <= t_d;
        end
    end

    assign x1Out     = x1_q;
    assign x2Out     = x2_q;
    assign tOut      = t_q;
    assign dataReady = dr_q;
    assign busy      = busy_q;
    assign epoch     = epoch_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed vector bench for sample_feeder: one table row per clock cycle, plus a
// long request-hold sequence checked cycle by cycle.
module tb_sample_feeder;

    logic              clk;
    logic              rst;
    logic              start;
    logic [31:0]       nSamples;
    logic              wrEn;
    logic [8:0]        wrAddr;
    logic signed [6:0] wrX1;
    logic signed [6:0] wrX2;
    logic signed [1:0] wrT;
    logic              requestFlag;
    logic              done;
    logic signed [6:0] x1Out;
    logic signed [6:0] x2Out;
    logic signed [1:0] tOut;
    logic              dataReady;
    logic              busy;
    logic [15:0]       epoch;
    logic              err;

    sample_feeder #(.DEPTH(512), .ADDR_W(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .nSamples    (nSamples),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrX1        (wrX1),
        .wrX2        (wrX2),
        .wrT         (wrT),
        .requestFlag (requestFlag),
        .done        (done),
        .x1Out       (x1Out),
        .x2Out       (x2Out),
        .tOut        (tOut),
        .dataReady   (dataReady),
        .busy        (busy),
        .epoch       (epoch),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] n;
        logic        we;
        logic [8:0]  wa;
        logic [6:0]  wx1;
        logic [6:0]  wx2;
        logic [1:0]  wt;
        logic        req;
        logic        done;
        logic        dr;
        logic [6:0]  ex1;
        logic [6:0]  ex2;
        logic [1:0]  et;
        logic        busy;
        logic [15:0] ep;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    function automatic vec_t v(int r, int s, int n, int we, int wa, int wx1, int wx2, int wt,
                               int req, int dn, int dr, int ex1, int ex2, int et, int bz,
                               int ep, int er);
        vec_t t;
        t.rst   = r[0];
        t.start = s[0];
        t.n     = n;
        t.we    = we[0];
        t.wa    = wa[8:0];
        t.wx1   = wx1[6:0];
        t.wx2   = wx2[6:0];
        t.wt    = wt[1:0];
        t.req   = req[0];
        t.done  = dn[0];
        t.dr    = dr[0];
        t.ex1   = ex1[6:0];
        t.ex2   = ex2[6:0];
        t.et    = et[1:0];
        t.busy  = bz[0];
        t.ep    = ep[15:0];
        t.err   = er[0];
        return t;
    endfunction

    task automatic apply_and_check(input vec_t t, input string name);
        logic [34:0] act;
        logic [34:0] exp;
        @(negedge clk);
        rst         = t.rst;
        start       = t.start;
        nSamples    = t.n;
        wrEn        = t.we;
        wrAddr      = t.wa;
        wrX1        = t.wx1;
        wrX2        = t.wx2;
        wrT         = t.wt;
        requestFlag = t.req;
        done        = t.done;
        @(posedge clk);
        #1;
        act = {dataReady, x1Out, x2Out, tOut, busy, epoch, err};
        exp = {t.dr, t.ex1, t.ex2, t.et, t.busy, t.ep, t.err};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got dr=%b x1=%0d x2=%0d t=%0d busy=%b epoch=%0d err=%b, want dr=%b x1=%0d x2=%0d t=%0d busy=%b epoch=%0d err=%b",
                     name, dataReady, x1Out, x2Out, tOut, busy, epoch, err,
                     t.dr, $signed(t.ex1), $signed(t.ex2), $signed(t.et), t.busy, t.ep, t.err);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        nSamples    = '0;
        wrEn        = 1'b0;
        wrAddr      = '0;
        wrX1        = '0;
        wrX2        = '0;
        wrT         = '0;
        requestFlag = 1'b0;
        done        = 1'b0;

        //        rst st n    we wa x1  x2  t   req dn   dr x1  x2  t   bz ep er
        vecs.push_back(v(1, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, 0,  0,  0,  0, 0, 0)); // 0 reset
        vecs.push_back(v(0, 0, 0,   1, 0, 5,  -3, 1,  0, 0,   0, 0,  0,  0,  0, 0, 0)); // 1 load
        vecs.push_back(v(0, 0, 0,   1, 1, -7, 2,  -1, 0, 0,   0, 0,  0,  0,  0, 0, 0)); // 2
        vecs.push_back(v(0, 0, 0,   1, 2, 0,  63, 1,  0, 0,   0, 0,  0,  0,  0, 0, 0)); // 3
        vecs.push_back(v(0, 1, 0,   0, 0, 0,  0,  0,  0, 0,   0, 0,  0,  0,  0, 0, 1)); // 4 n=0
        vecs.push_back(v(0, 1, 600, 0, 0, 0,  0,  0,  0, 0,   0, 0,  0,  0,  0, 0, 1)); // 5 n=600
        vecs.push_back(v(0, 1, 3,   0, 0, 0,  0,  0,  0, 0,   0, 0,  0,  0,  1, 0, 0)); // 6 start
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, 5,  -3, 1,  1, 0, 0)); // 7 s0
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, 5,  -3, 1,  1, 0, 0)); // 8 hold
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, 5,  -3, 1,  1, 0, 0)); // 9 rel
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, -7, 2,  -1, 1, 0, 0)); // 10 s1
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, -7, 2,  -1, 1, 0, 0)); // 11 rel
        vecs.push_back(v(0, 0, 0,   1, 0, 1,  1,  1,  0, 0,   0, -7, 2,  -1, 1, 0, 0)); // 12 wr busy
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, 0,  63, 1,  1, 0, 0)); // 13 s2
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, 0,  63, 1,  1, 1, 0)); // 14 wrap
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, 5,  -3, 1,  1, 1, 0)); // 15 s0
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, 5,  -3, 1,  1, 1, 0)); // 16 rel
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, -7, 2,  -1, 1, 1, 0)); // 17 s1
        vecs.push_back(v(0, 1, 2,   0, 0, 0,  0,  0,  1, 0,   1, -7, 2,  -1, 1, 1, 0)); // 18 st ign
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 1,   0, -7, 2,  -1, 0, 1, 0)); // 19 done
        vecs.push_back(v(0, 1, 3,   0, 0, 0,  0,  0,  0, 0,   0, -7, 2,  -1, 1, 0, 0)); // 20 start
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, 5,  -3, 1,  1, 0, 0)); // 21 s0
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, 5,  -3, 1,  1, 0, 0)); // 22 rel
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, -7, 2,  -1, 1, 0, 0)); // 23 s1
        vecs.push_back(v(1, 0, 0,   0, 0, 0,  0,  0,  1, 0,   0, 0,  0,  0,  0, 0, 0)); // 24 rst
        vecs.push_back(v(0, 1, 3,   0, 0, 0,  0,  0,  0, 0,   0, 0,  0,  0,  1, 0, 0)); // 25 start
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   1, 5,  -3, 1,  1, 0, 0)); // 26 s0
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  0, 0,   0, 5,  -3, 1,  1, 0, 0)); // 27 rel
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 1,   0, 5,  -3, 1,  0, 0, 0)); // 28 done
        vecs.push_back(v(0, 0, 0,   0, 0, 0,  0,  0,  1, 0,   0, 5,  -3, 1,  0, 0, 0)); // 29 idle

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 16) begin
                // Consumer keeps requesting: sample 0 must stay presented, idx frozen.
                for (int k = 0; k < 10; k++) begin
                    apply_and_check(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, -3, 1, 1, 1, 0),
                                    $sformatf("hold_cycle_%0d", k));
                end
            end
            apply_and_check(vecs[i], $sformatf("vec_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
